// File: rtl/uart_reg_bank_if.sv
// CPU-side register port for the UART CSR bank.
// Single-cycle request, response exactly one cycle later.
interface uart_reg_bank_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 32
);
  logic                   req;
  logic                   we;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [REG_WIDTH/8-1:0] be;
  logic [REG_WIDTH-1:0]   wdata;
  logic                   ack;
  logic                   err;
  logic [REG_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/uart_reg_bank.sv
// Multi-register UART CSR bank with per-bit access types,
// sticky event inputs and a registered interrupt request.
module uart_reg_bank #(
  parameter int NUM_REGS   = 4,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 3,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]
    RW_PATTERN     = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]
    RC_PATTERN     = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]
    W1C_PATTERN    = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]
    PERIPH_PATTERN = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]
    RESET_VALUE    = '0,
  parameter int IRQ_STAT_IDX = 0,
  parameter int IRQ_EN_IDX   = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  uart_reg_bank_if.slave cpu,
  input  logic [NUM_REGS-1:0] periph_we_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0]
    periph_wdata_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0]
    periph_set_i,
  output logic [NUM_REGS*REG_WIDTH-1:0]
    regs_o,
  output logic irq_o
);

  localparam int NB = REG_WIDTH / 8;
  localparam int TW = NUM_REGS * REG_WIDTH;
  localparam logic [31:0] NR = NUM_REGS;

  logic [TW-1:0]        q;
  logic [TW-1:0]        d;
  logic [31:0]          addr_x;
  logic                 hit;
  logic                 sel;
  logic [REG_WIDTH-1:0] mask;
  logic [REG_WIDTH-1:0] cur;
  logic [REG_WIDTH-1:0] nxt;
  logic [REG_WIDTH-1:0] rsel;
  logic [REG_WIDTH-1:0] wm;

  assign addr_x = 32'(cpu.addr);
  assign hit    = cpu.req && (addr_x < NR);
  assign regs_o = q;

  // Apply lowest priority first so later steps override.
  always_comb begin
    mask = '0;
    d    = q;
    rsel = '0;
    cur  = '0;
    nxt  = '0;
    sel  = 1'b0;
    wm   = '0;
    for (int i = 0; i < NB; i++)
      mask[i*8 +: 8] = {8{cpu.be[i]}};
    for (int r = 0; r < NUM_REGS; r++) begin
      cur = q[r*REG_WIDTH +: REG_WIDTH];
      nxt = cur;
      sel = hit && (addr_x == 32'(r));
      if (sel)
        rsel = cur;
      if (sel && !cpu.we)
        nxt &= ~RC_PATTERN[r*REG_WIDTH +: REG_WIDTH];
      if (periph_we_i[r]) begin
        wm  = PERIPH_PATTERN[r*REG_WIDTH +: REG_WIDTH];
        nxt = (nxt & ~wm)
            | (periph_wdata_i[r*REG_WIDTH +: REG_WIDTH] & wm);
      end
      if (sel && cpu.we) begin
        wm  = RW_PATTERN[r*REG_WIDTH +: REG_WIDTH] & mask;
        nxt = (nxt & ~wm) | (cpu.wdata & wm);
        wm  = W1C_PATTERN[r*REG_WIDTH +: REG_WIDTH] & mask;
        nxt &= ~(wm & cpu.wdata);
      end
      nxt |= periph_set_i[r*REG_WIDTH +: REG_WIDTH];
      d[r*REG_WIDTH +: REG_WIDTH] = nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q         <= RESET_VALUE;
      cpu.ack   <= 1'b0;
      cpu.err   <= 1'b0;
      cpu.rdata <= '0;
      irq_o     <= 1'b0;
    end else begin
      q       <= d;
      cpu.ack <= cpu.req;
      cpu.err <= cpu.req && !hit;
      if (cpu.req && (!cpu.we || !hit))
        cpu.rdata <= rsel;
      irq_o <= |(q[IRQ_STAT_IDX*REG_WIDTH +: REG_WIDTH]
               & q[IRQ_EN_IDX*REG_WIDTH +: REG_WIDTH]);
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed scoreboard bench for the UART CSR bank.
// Expected responses are queued at drive time and popped at ack.
module tb_uart_reg_bank;

  localparam int NR = 4;
  localparam int RW = 32;
  localparam int AW = 3;
  localparam int TW = NR * RW;

  localparam logic [TW-1:0] RWP =
    {32'hFFFFFFFF, 32'h0, 32'hFF000000, 32'h000000FF};
  localparam logic [TW-1:0] RCP =
    {32'h0, 32'h00000010, 32'h0, 32'h0};
  localparam logic [TW-1:0] W1CP =
    {32'h0, 32'h01000000, 32'h0000000F, 32'h0};
  localparam logic [TW-1:0] PERP =
    {32'h0, 32'h0, 32'h0, 32'h0000FFFF};
  localparam logic [TW-1:0] RSTV =
    {32'h0, 32'h0, 32'h0100000F, 32'h0000005A};

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NR-1:0] periph_we;
  logic [TW-1:0] periph_wdata;
  logic [TW-1:0] periph_set;
  logic [TW-1:0] regs;
  logic irq;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] lastrd;
  logic [TW-1:0] snap;

  uart_reg_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

  uart_reg_bank #(
    .NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_WIDTH(AW),
    .RW_PATTERN(RWP), .RC_PATTERN(RCP),
    .W1C_PATTERN(W1CP), .PERIPH_PATTERN(PERP),
    .RESET_VALUE(RSTV),
    .IRQ_STAT_IDX(2), .IRQ_EN_IDX(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .cpu(bus),
    .periph_we_i(periph_we),
    .periph_wdata_i(periph_wdata),
    .periph_set_i(periph_set),
    .regs_o(regs),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [TW-1:0] got,
                     input logic [TW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    bus.req      = 1'b0;
    periph_we    = '0;
    periph_wdata = '0;
    periph_set   = '0;
  endtask

  task automatic access(input string tag,
                        input logic we,
                        input logic [AW-1:0] a,
                        input logic [3:0] be,
                        input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    exp_t e;
    exp_t g;
    e.err   = (32'(a) >= NR);
    e.rdata = e.err ? 32'h0 : (we ? lastrd : exp_rd);
    lastrd  = e.rdata;
    sb.push_back(e);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.be    = be;
    bus.wdata = wd;
    cycle();
    chk({tag, "_ack"}, TW'(bus.ack), TW'(1'b1));
    g = sb.pop_front();
    chk({tag, "_err"}, TW'(bus.err), TW'(g.err));
    chk({tag, "_rdata"}, TW'(bus.rdata), TW'(g.rdata));
  endtask

  initial begin
    rst_ni       = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = '0;
    bus.be       = '0;
    bus.wdata    = '0;
    periph_we    = '0;
    periph_wdata = '0;
    periph_set   = '0;
    lastrd       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", TW'(bus.ack), '0);
    chk("rst_err", TW'(bus.err), '0);
    chk("rst_irq", TW'(irq), '0);
    chk("rst_rdata", TW'(bus.rdata), '0);
    chk("rst_regs", regs, RSTV);
    @(negedge clk);
    rst_ni = 1'b1;

    access("rd0_rst", 1'b0, 3'd0, 4'h0, 32'h0, 32'h5A);
    access("wr0", 1'b1, 3'd0, 4'h1, 32'hFFFFFFC3, 32'h0);
    access("rd0_wr", 1'b0, 3'd0, 4'h0, 32'h0, 32'hC3);
    cycle();
    chk("idle_ack", TW'(bus.ack), '0);

    access("wr3_be", 1'b1, 3'd3, 4'b0101, 32'hAABBCCDD, 32'h0);
    access("rd3_be", 1'b0, 3'd3, 4'h0, 32'h0, 32'h00BB00DD);

    periph_set[2*RW+4] = 1'b1;
    cycle();
    access("rc_1", 1'b0, 3'd2, 4'h0, 32'h0, 32'h10);
    access("rc_2", 1'b0, 3'd2, 4'h0, 32'h0, 32'h0);
    periph_set[2*RW+4] = 1'b1;
    cycle();
    periph_set[2*RW+4] = 1'b1;
    access("rc_set", 1'b0, 3'd2, 4'h0, 32'h0, 32'h10);
    access("rc_kept", 1'b0, 3'd2, 4'h0, 32'h0, 32'h10);
    access("rc_clr", 1'b0, 3'd2, 4'h0, 32'h0, 32'h0);

    access("w1c_a", 1'b1, 3'd1, 4'h1, 32'h05, 32'h0);
    access("w1c_rd", 1'b0, 3'd1, 4'h0, 32'h0, 32'h0100000A);
    periph_set[1*RW+1] = 1'b1;
    access("w1c_set", 1'b1, 3'd1, 4'h1, 32'h02, 32'h0);
    access("w1c_kept", 1'b0, 3'd1, 4'h0, 32'h0, 32'h0100000A);
    access("w1c_b", 1'b1, 3'd1, 4'h1, 32'h02, 32'h0);
    access("w1c_rd2", 1'b0, 3'd1, 4'h0, 32'h0, 32'h01000008);

    snap = regs;
    access("err_wr", 1'b1, 3'd5, 4'hF, 32'hFFFFFFFF, 32'h0);
    chk("err_regs", regs, snap);
    access("err_rd", 1'b0, 3'd7, 4'h0, 32'h0, 32'h0);

    periph_set[2*RW+24] = 1'b1;
    cycle();
    chk("irq_lag", TW'(irq), '0);
    chk("irq_stat", TW'(regs[2*RW +: RW]), TW'(32'h01000000));
    cycle();
    chk("irq_on", TW'(irq), TW'(1'b1));
    access("irq_w1c", 1'b1, 3'd2, 4'b1000, 32'h01000000, 32'h0);
    chk("irq_hold", TW'(irq), TW'(1'b1));
    cycle();
    chk("irq_off", TW'(irq), '0);

    periph_we = 4'b0001;
    periph_wdata[31:0] = 32'h0000ABCD;
    access("prio_wr", 1'b1, 3'd0, 4'h1, 32'h11, 32'h0);
    chk("prio_reg", TW'(regs[31:0]), TW'(32'h0000AB11));
    periph_we = 4'b0001;
    periph_wdata[31:0] = 32'h00001234;
    cycle();
    access("per_rd", 1'b0, 3'd0, 4'h0, 32'h0, 32'h1234);

    @(negedge clk);
    rst_ni    = 1'b0;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 3'd3;
    bus.be    = 4'hF;
    bus.wdata = 32'hFFFFFFFF;
    cycle();
    chk("rst_mid_ack", TW'(bus.ack), '0);
    chk("rst_mid_regs", regs, RSTV);
    chk("rst_mid_rdata", TW'(bus.rdata), '0);
    lastrd = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    access("post_rd3", 1'b0, 3'd3, 4'h0, 32'h0, 32'h0);
    access("post_rd0", 1'b0, 3'd0, 4'h0, 32'h0, 32'h5A);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
